fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage wrapped around the PC register: it takes the current `pc`, fetches from instruction memory over a req/ack handshake, and presents one instruction at a time to decode with a valid/ready handshake. It also generates `next_pc` for the PC register: hold while waiting, step on fetch completion, or load a redirect target from execute. The design is single-issue; one request is outstanding at most.

## Interface
- `PC_STEP`, default 4: increment applied to `pc` on fetch completion.
- `FAULT_INST`, default 32'h0000_0000: value driven on `inst` for a faulting fetch.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pc` in 32: current PC from the PC register.
- `next_pc` out 32: combinational; drives the PC register input.
- `imem_req` out 1: fetch request, registered state-driven.
- `imem_addr` out 32: fetch address.
- `imem_ack` in 1: memory completion; `imem_rdata` is valid in this cycle.
- `imem_rdata` in 32: fetched word.
- `inst` out 32: instruction to decode (registered).
- `inst_pc` out 32: PC of `inst` (registered).
- `inst_valid` out 1: `inst` holds a valid instruction.
- `inst_ready` in 1: decode accepts `inst`.
- `redirect` in 1: branch/jump taken; flush and refetch.
- `redirect_pc` in 32: redirect target.
- `fetch_fault` out 1: misaligned fetch flag. Tied 0 when the macro is absent.

## Operation
- States:
  - IDLE: post-reset.
  - WAIT: request issued, waiting for ack.
  - FULL: instruction held for decode.
  - DROP: stale request outstanding after a redirect.
- IDLE:
  - Go to WAIT next cycle.
  - `next_pc = pc`.
  - With `redirect`, `next_pc = redirect_pc`.
- WAIT:
  - `imem_req=1` and `imem_addr=pc`.
  - On `imem_ack`: `inst<=imem_rdata`, `inst_pc<=pc`, `inst_valid<=1`, `next_pc=pc+PC_STEP` (mod 2^32, wraps 0xFFFF_FFFC→0), go to FULL.
  - Without ack: `next_pc=pc`, stay in WAIT.
- FULL:
  - `imem_req=0` and `next_pc=pc`.
  - On `inst_valid && inst_ready`: `inst_valid<=0`, go to WAIT.
- DROP:
  - `imem_req=1` and `imem_addr=held_addr`.
  - On ack, discard `imem_rdata` and go to WAIT.
  - `next_pc=pc`, or `redirect_pc` if `redirect` is asserted again. The latest redirect wins.
- `redirect` has priority over all other events and always sets `next_pc=redirect_pc` and `inst_valid<=0`:
  - IDLE/FULL: go to WAIT. In FULL, a simultaneous `inst_ready` does not count as a handshake; the instruction is dropped.
  - WAIT with `imem_ack` in the same cycle: data discarded, stay in WAIT.
  - WAIT without ack: `held_addr<=pc`, go to DROP.
- Memory rule: `imem_addr` is stable while `imem_req=1` and no ack has been seen. `imem_rdata` is sampled only when `imem_ack=1`. Acks while `imem_req=0` are ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `imem_req=0`, `inst=0`, `inst_pc=0`, `inst_valid=0`, `fetch_fault=0`, `held_addr=0`.
- A reset mid-request abandons the request; `imem_req` drops immediately.
- Zero-wait memory (ack in the request cycle):
  - Instruction visible 1 cycle after the request cycle.
  - PC register updates on the same edge.
  - Peak throughput is 1 instruction per 2 cycles.
- N-cycle memory latency: `imem_req` held N+1 cycles, then `inst_valid` rises on the next edge.
- `inst`, `inst_pc` and `fetch_fault` are stable while `inst_valid=1 && !inst_ready`.

## Configuration
- Macro `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - In WAIT with `pc[1:0]!=0` and no `redirect`: `imem_req=0`, `inst<=FAULT_INST`, `inst_pc<=pc`, `inst_valid<=1`, `fetch_fault<=1`, `next_pc=pc`, go to FULL.
  - `fetch_fault` clears when the instruction is consumed or flushed.
  - Only a redirect recovers from the fault.
- Undefined:
  - `fetch_fault` is constant 0.
  - `pc` goes to `imem_addr` unmodified regardless of alignment.

## Test plan
- Reset release, zero-wait memory returning `pc`, `inst_ready=1`:
  - Instructions at `inst_pc` 0x0, 0x4, 0x8 with `inst_valid` high every other cycle.
  - `next_pc` pulses 0x4, 0x8, 0xC.
- Memory ack 2 cycles after the request:
  - `imem_req` high 3 cycles with `imem_addr=0x0` stable.
  - `next_pc=0x0` until ack, then 0x4.
- `inst_ready=0` for 5 cycles with `inst_valid=1`:
  - `inst` and `inst_pc` unchanged.
  - `imem_req=0` and `next_pc=pc`.
  - Fetch resumes one cycle after `inst_ready=1`.
- At pc 0x8 in WAIT without ack, `redirect=1` with `redirect_pc=0x100`:
  - DROP with `imem_addr` held at 0x8 until ack.
  - Data discarded, no `inst_valid`.
  - Next request at 0x100.
- FULL with `inst_ready=1` and `redirect=1` to 0x200 in the same cycle:
  - `inst_valid=0` next cycle.
  - No handshake counted.
  - Next `inst_pc=0x200`.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102:
  - Memory is never requested.
  - `inst_valid=1`, `fetch_fault=1`, `inst=0`, `inst_pc=0x102`.
  - A redirect to 0x104 clears the fault.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage around the PC register. Issues one
//             req/ack memory fetch at a time, hands the fetched word to
//             decode over valid/ready, and produces next_pc (hold, step or
//             redirect target).
//  Options  : FETCH_ALIGN_CHECK_EN - when defined, a misaligned pc is not
//             sent to memory; a faulting instruction (FAULT_INST) is
//             presented with fetch_fault set instead.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter logic [31:0] FAULT_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;  // just out of reset
    localparam logic [1:0] ST_WAIT = 2'd1;  // request out, waiting for ack
    localparam logic [1:0] ST_FULL = 2'd2;  // instruction held for decode
    localparam logic [1:0] ST_DROP = 2'd3;  // stale request still outstanding

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] held_addr;
    logic        misaligned;

    // Datapath strobes decoded from state and inputs.
    logic        load_inst;    // capture imem_rdata into inst
    logic        load_fault;   // present FAULT_INST instead of fetching
    logic        clear_valid;  // instruction consumed or flushed
    logic        hold_load;    // remember address of a request being dropped

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State register; reset abandons any outstanding request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; redirect outranks every other event.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    // Only an unacknowledged live request must be drained.
                    state_next = (!misaligned && !imem_ack) ? ST_DROP : ST_WAIT;
                end else if (misaligned || imem_ack) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect || inst_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_DROP: begin
                // A new redirect just moves next_pc; the old request still
                // has to complete before a new one can start.
                if (imem_ack) begin
                    state_next = ST_WAIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Memory request, next_pc selection and datapath strobes.
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = pc;
        next_pc     = pc;
        load_inst   = 1'b0;
        load_fault  = 1'b0;
        clear_valid = 1'b0;
        hold_load   = 1'b0;
        case (state)
            ST_WAIT: begin
                imem_req = !misaligned;
                if (redirect) begin
                    hold_load = !misaligned && !imem_ack;
                end else if (misaligned) begin
                    load_fault = 1'b1;
                end else if (imem_ack) begin
                    load_inst = 1'b1;
                    next_pc   = pc + PC_STEP;
                end
            end
            ST_FULL: begin
                clear_valid = inst_ready;
            end
            ST_DROP: begin
                imem_req  = 1'b1;
                imem_addr = held_addr;
            end
            default: begin
            end
        endcase
        if (redirect) begin
            next_pc     = redirect_pc;
            clear_valid = 1'b1;
        end
    end

    // Instruction buffer toward decode plus the held address of a dropped fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst       <= 32'h0000_0000;
            inst_pc    <= 32'h0000_0000;
            inst_valid <= 1'b0;
            held_addr  <= 32'h0000_0000;
        end else begin
            if (load_inst) begin
                inst       <= imem_rdata;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else if (load_fault) begin
                inst       <= FAULT_INST;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else if (clear_valid) begin
                inst_valid <= 1'b0;
            end
            if (hold_load) begin
                held_addr <= pc;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_flag;

    // Fault flag travels with the faulting instruction and leaves with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_flag <= 1'b0;
        end else if (load_fault) begin
            fault_flag <= 1'b1;
        end else if (clear_valid) begin
            fault_flag <= 1'b0;
        end
    end

    assign fetch_fault = fault_flag;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit. Holds the PC register and a
//             memory whose word is its address xor a tag; a table of per-cycle
//             stimulus/expectation rows plus short hand-written sequences for
//             the alignment fault and reset mid-request.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] TAG = 32'h5A00_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // PC register fed by the fetch unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'h0;
        else       pc <= next_pc;
    end

    // Memory word is derived from the address so captures are traceable.
    assign imem_rdata = imem_addr ^ TAG;

    typedef struct packed {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_next;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ack, input logic ready, input logic redir,
                                input logic [31:0] rpc, input logic [31:0] e_next,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_ipc);
        vec_t v;
        v.ack = ack; v.ready = ready; v.redir = redir; v.rpc = rpc;
        v.e_next = e_next; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //                ack rdy rd  rpc           next          req addr          vld ipc
        vecs[0]  = mk(0, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0);   // IDLE
        vecs[1]  = mk(1, 1, 0, 32'h0,        32'h4,        1, 32'h0,        0, 32'h0);   // zero-wait
        vecs[2]  = mk(0, 1, 0, 32'h0,        32'h4,        0, 32'h4,        1, 32'h0);
        vecs[3]  = mk(1, 1, 0, 32'h0,        32'h8,        1, 32'h4,        0, 32'h0);
        vecs[4]  = mk(0, 1, 0, 32'h0,        32'h8,        0, 32'h8,        1, 32'h4);
        vecs[5]  = mk(1, 1, 0, 32'h0,        32'hC,        1, 32'h8,        0, 32'h4);
        vecs[6]  = mk(0, 1, 0, 32'h0,        32'hC,        0, 32'hC,        1, 32'h8);
        vecs[7]  = mk(0, 1, 0, 32'h0,        32'hC,        1, 32'hC,        0, 32'h8);   // 2-cycle latency
        vecs[8]  = mk(0, 1, 0, 32'h0,        32'hC,        1, 32'hC,        0, 32'h8);
        vecs[9]  = mk(1, 1, 0, 32'h0,        32'h10,       1, 32'hC,        0, 32'h8);
        vecs[10] = mk(0, 0, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);   // stall 5 cycles
        vecs[11] = mk(1, 0, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);   // stray ack ignored
        vecs[12] = mk(0, 0, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);
        vecs[13] = mk(0, 0, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);
        vecs[14] = mk(0, 0, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);
        vecs[15] = mk(0, 1, 0, 32'h0,        32'h10,       0, 32'h10,       1, 32'hC);
        vecs[16] = mk(1, 1, 0, 32'h0,        32'h14,       1, 32'h10,       0, 32'hC);
        vecs[17] = mk(0, 1, 0, 32'h0,        32'h14,       0, 32'h14,       1, 32'h10);
        vecs[18] = mk(0, 1, 1, 32'h100,      32'h100,      1, 32'h14,       0, 32'h10);  // redirect in WAIT
        vecs[19] = mk(0, 1, 0, 32'h0,        32'h100,      1, 32'h14,       0, 32'h10);  // DROP holds addr
        vecs[20] = mk(1, 1, 0, 32'h0,        32'h100,      1, 32'h14,       0, 32'h10);
        vecs[21] = mk(1, 1, 0, 32'h0,        32'h104,      1, 32'h100,      0, 32'h10);
        vecs[22] = mk(0, 1, 1, 32'h200,      32'h200,      0, 32'h104,      1, 32'h100); // redirect+ready in FULL
        vecs[23] = mk(0, 1, 0, 32'h0,        32'h200,      1, 32'h200,      0, 32'h100);
        vecs[24] = mk(1, 1, 0, 32'h0,        32'h204,      1, 32'h200,      0, 32'h100);
        vecs[25] = mk(0, 0, 0, 32'h0,        32'h204,      0, 32'h204,      1, 32'h200);
        vecs[26] = mk(0, 1, 0, 32'h0,        32'h204,      0, 32'h204,      1, 32'h200);
        vecs[27] = mk(1, 1, 1, 32'h300,      32'h300,      1, 32'h204,      0, 32'h200); // redirect+ack in WAIT
        vecs[28] = mk(0, 1, 0, 32'h0,        32'h300,      1, 32'h300,      0, 32'h200);
        vecs[29] = mk(0, 1, 1, 32'h400,      32'h400,      1, 32'h300,      0, 32'h200);
        vecs[30] = mk(0, 1, 1, 32'h500,      32'h500,      1, 32'h300,      0, 32'h200); // latest redirect wins
        vecs[31] = mk(1, 1, 0, 32'h0,        32'h500,      1, 32'h300,      0, 32'h200);
        vecs[32] = mk(1, 1, 0, 32'h0,        32'h504,      1, 32'h500,      0, 32'h200);
        vecs[33] = mk(0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h504,      1, 32'h500);
        vecs[34] = mk(1, 1, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 0, 32'h500); // pc wraps
        vecs[35] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hFFFFFFFC);
        vecs[36] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'hFFFFFFFC);

        reset       = 1'b1;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        #12;
        check("reset imem_req",    {31'b0, imem_req},    32'h0);
        check("reset inst",        inst,                 32'h0);
        check("reset inst_pc",     inst_pc,              32'h0);
        check("reset inst_valid",  {31'b0, inst_valid},  32'h0);
        check("reset fetch_fault", {31'b0, fetch_fault}, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            imem_ack    = vecs[i].ack;
            inst_ready  = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("row%0d next_pc", i),    next_pc,              vecs[i].e_next);
            check($sformatf("row%0d imem_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].e_req});
            check($sformatf("row%0d imem_addr", i),  imem_addr,            vecs[i].e_addr);
            check($sformatf("row%0d inst_valid", i), {31'b0, inst_valid},  {31'b0, vecs[i].e_valid});
            check($sformatf("row%0d inst_pc", i),    inst_pc,              vecs[i].e_ipc);
            check($sformatf("row%0d fetch_fault", i), {31'b0, fetch_fault}, 32'h0);
            if (vecs[i].e_valid)
                check($sformatf("row%0d inst", i), inst, vecs[i].e_ipc ^ TAG);
            @(negedge clk);
        end

        // Redirect from FULL to a misaligned target.
        imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
        #1;
        check("mis redirect next_pc", next_pc, 32'h102);
        @(negedge clk);
        // WAIT at 0x102: memory untouched when the alignment check is built in.
        redirect = 1'b0; imem_ack = 1'b1;
        #1;
        check("mis imem_req", {31'b0, imem_req}, ALIGN ? 32'h0 : 32'h1);
        check("mis next_pc",  next_pc,           ALIGN ? 32'h102 : 32'h106);
        check("mis valid before", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check("mis inst_valid",  {31'b0, inst_valid},  32'h1);
        check("mis inst_pc",     inst_pc,              32'h102);
        check("mis inst",        inst,                 ALIGN ? 32'h0 : (32'h102 ^ TAG));
        check("mis fetch_fault", {31'b0, fetch_fault}, ALIGN ? 32'h1 : 32'h0);
        check("mis full req",    {31'b0, imem_req},    32'h0);
        redirect = 1'b1; redirect_pc = 32'h104;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("rec inst_valid",  {31'b0, inst_valid},  32'h0);
        check("rec fetch_fault", {31'b0, fetch_fault}, 32'h0);
        check("rec imem_req",    {31'b0, imem_req},    32'h1);
        check("rec imem_addr",   imem_addr,            32'h104);

        // Reset while a request is outstanding drops it without a clock edge.
        #1;
        reset = 1'b1;
        #1;
        check("midreset imem_req",   {31'b0, imem_req},   32'h0);
        check("midreset inst_valid", {31'b0, inst_valid}, 32'h0);
        check("midreset inst_pc",    inst_pc,             32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
